// File: rtl/id_ex_issue_pkg.sv
// rtl/id_ex_issue_pkg.sv - shared ALU encodings and operand forwarding helper
//
// Purpose: constants shared by the ID/EX issue stage, the EX ALU and the main
//          decoder, plus the operand-forwarding selection function.
// Contents:
//   ALU_* : 4-bit ALU control codes driven into the EX ALU
//   alu_op_e : 2-bit ALU_Op encoding from the main decoder
//   FUNCT_* : R-type funct values understood by the ALU control decode
//   fwd_operand : MEM-over-WB bypass selection for one register operand
package id_ex_issue_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_OR    = 2'b11
  } alu_op_e;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // The younger result (MEM) wins over WB; $0 is never bypassed because a
  // writer index of 0 never qualifies.
  function automatic logic [31:0] fwd_operand(
    input logic [31:0] reg_val,
    input logic [4:0]  idx,
    input logic        mem_we,
    input logic [4:0]  mem_idx,
    input logic [31:0] mem_val,
    input logic        wb_we,
    input logic [4:0]  wb_idx,
    input logic [31:0] wb_val
  );
    logic [31:0] v;
    v = reg_val;
    if (mem_we && (mem_idx != 5'd0) && (mem_idx == idx)) begin
      v = mem_val;
    end else if (wb_we && (wb_idx != 5'd0) && (wb_idx == idx)) begin
      v = wb_val;
    end
    return v;
  endfunction

endpackage

// File: rtl/id_ex_issue_if.sv
// rtl/id_ex_issue_if.sv - ID-side inputs and EX-side ALU outputs of the issue stage
//
// Purpose: bundles the ID/EX issue stage signals (optional MEM/WB bypass
//          inputs exist only when FORWARDING_EN is defined).
// Modports:
//   master : the issue stage (consumes ID fields, drives EX operands/controls)
//   slave  : the surrounding pipeline (drives ID fields, consumes EX side)
interface id_ex_issue_if;
  import id_ex_issue_pkg::*;

  logic        Valid_ID;
  logic        Ready_ID;
  logic [31:0] Read_Data_1_ID;
  logic [31:0] Read_Data_2_ID;
  logic [31:0] Sign_Ext_Imm_ID;
  logic [4:0]  Rs_ID;
  logic [4:0]  Rt_ID;
  logic [4:0]  Rd_ID;
  logic [1:0]  ALU_Op_ID;
  logic [5:0]  Funct_ID;
  logic        ALU_Src_ID;
  logic        Reg_Dst_ID;
  logic        Mem_Read_ID;
  logic        Reg_Write_ID;
  logic        Flush_EX;

  logic [31:0] Read_Data_1_EX;
  logic [31:0] ALU_Data_2_EX;
  logic [3:0]  ALU_Control_EX;
  logic [4:0]  Write_Reg_EX;
  logic        Mem_Read_EX;
  logic        Reg_Write_EX;
  logic        Valid_EX;
  logic        Illegal_EX;
  logic [15:0] Bubble_Count;

`ifdef FORWARDING_EN
  logic [31:0] ALU_Result_MEM;
  logic [4:0]  Write_Reg_MEM;
  logic        Reg_Write_MEM;
  logic [31:0] Write_Data_WB;
  logic [4:0]  Write_Reg_WB;
  logic        Reg_Write_WB;
`endif

  modport master (
`ifdef FORWARDING_EN
    input  ALU_Result_MEM, Write_Reg_MEM, Reg_Write_MEM,
    input  Write_Data_WB, Write_Reg_WB, Reg_Write_WB,
`endif
    input  Valid_ID, Read_Data_1_ID, Read_Data_2_ID, Sign_Ext_Imm_ID,
    input  Rs_ID, Rt_ID, Rd_ID, ALU_Op_ID, Funct_ID,
    input  ALU_Src_ID, Reg_Dst_ID, Mem_Read_ID, Reg_Write_ID, Flush_EX,
    output Ready_ID,
    output Read_Data_1_EX, ALU_Data_2_EX, ALU_Control_EX, Write_Reg_EX,
    output Mem_Read_EX, Reg_Write_EX, Valid_EX, Illegal_EX, Bubble_Count
  );

  modport slave (
`ifdef FORWARDING_EN
    output ALU_Result_MEM, Write_Reg_MEM, Reg_Write_MEM,
    output Write_Data_WB, Write_Reg_WB, Reg_Write_WB,
`endif
    output Valid_ID, Read_Data_1_ID, Read_Data_2_ID, Sign_Ext_Imm_ID,
    output Rs_ID, Rt_ID, Rd_ID, ALU_Op_ID, Funct_ID,
    output ALU_Src_ID, Reg_Dst_ID, Mem_Read_ID, Reg_Write_ID, Flush_EX,
    input  Ready_ID,
    input  Read_Data_1_EX, ALU_Data_2_EX, ALU_Control_EX, Write_Reg_EX,
    input  Mem_Read_EX, Reg_Write_EX, Valid_EX, Illegal_EX, Bubble_Count
  );

endinterface

// File: rtl/id_ex_issue_alu_control_decode.sv
// rtl/id_ex_issue_alu_control_decode.sv - ALU_Op/funct to 4-bit ALU control
//
// Purpose: combinational ALU control decode.
// Ports:
//   i_alu_op   in  2  ALU_Op from the main decoder
//   i_funct    in  6  R-type funct field
//   o_alu_ctrl out 4  ALU control code (ADD for unknown funct)
//   o_illegal  out 1  ALU_Op selects funct decode but funct is not supported
module alu_control_decode
  import id_ex_issue_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [5:0] i_funct,
  output logic [3:0] o_alu_ctrl,
  output logic       o_illegal
);

  always_comb begin
    o_alu_ctrl = ALU_ADD;
    o_illegal  = 1'b0;
    case (alu_op_e'(i_alu_op))
      ALUOP_ADD: o_alu_ctrl = ALU_ADD;
      ALUOP_SUB: o_alu_ctrl = ALU_SUB;
      ALUOP_OR:  o_alu_ctrl = ALU_OR;
      ALUOP_FUNCT: begin
        case (i_funct)
          FUNCT_ADD: o_alu_ctrl = ALU_ADD;
          FUNCT_SUB: o_alu_ctrl = ALU_SUB;
          FUNCT_AND: o_alu_ctrl = ALU_AND;
          FUNCT_OR:  o_alu_ctrl = ALU_OR;
          FUNCT_SLT: o_alu_ctrl = ALU_SLT;
          default:   o_illegal  = 1'b1;
        endcase
      end
      default: o_alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/id_ex_issue.sv
// rtl/id_ex_issue.sv - MIPS32 ID/EX issue stage with load-use stall and flush
//
// Purpose: registers the decoded instruction into EX, generates the ALU
//          control code, selects the second ALU operand, stalls ID on a
//          load-use hazard and squashes on Flush_EX. Optional MEM/WB operand
//          bypass is built when FORWARDING_EN is defined.
// Ports:
//   Clk     in  rising-edge clock
//   Reset_n in  asynchronous active-low reset
//   bus     id_ex_issue_if.master: ID fields, Flush_EX, Ready_ID, EX outputs,
//           Bubble_Count and (FORWARDING_EN) the MEM/WB bypass inputs
module id_ex_issue
  import id_ex_issue_pkg::*;
(
  input logic           Clk,
  input logic           Reset_n,
  id_ex_issue_if.master bus
);

  logic        r_valid;
  logic        r_mem_read;
  logic        r_reg_write;
  logic        r_illegal;
  logic [3:0]  r_alu_ctrl;
  logic [4:0]  r_write_reg;
  logic [31:0] r_rd1;
  logic [31:0] r_rd2;
  logic [31:0] r_imm;
  logic        r_alu_src;
  logic [15:0] r_bubble_count;

  logic        w_hazard;
  logic        w_take;
  logic [3:0]  w_alu_ctrl;
  logic        w_illegal;
  logic [31:0] w_rs_val;
  logic [31:0] w_rt_val;

  alu_control_decode u_alu_control_decode (
    .i_alu_op   (bus.ALU_Op_ID),
    .i_funct    (bus.Funct_ID),
    .o_alu_ctrl (w_alu_ctrl),
    .o_illegal  (w_illegal)
  );

  // A load in EX whose result the ID instruction reads; rt only counts when
  // it is used as a register operand (not replaced by the immediate).
  assign w_hazard = r_valid && r_mem_read && (r_write_reg != 5'd0) &&
                    ((r_write_reg == bus.Rs_ID) ||
                     ((r_write_reg == bus.Rt_ID) && !bus.ALU_Src_ID));

  // A flushed ID instruction is discarded anyway, so there is nothing to hold.
  assign bus.Ready_ID = !w_hazard || bus.Flush_EX;

  // Capture only when no flush, no hazard and ID is valid; otherwise a bubble.
  assign w_take = bus.Valid_ID && !bus.Flush_EX && !w_hazard;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_valid        <= 1'b0;
      r_mem_read     <= 1'b0;
      r_reg_write    <= 1'b0;
      r_illegal      <= 1'b0;
      r_alu_ctrl     <= ALU_ADD;
      r_write_reg    <= 5'd0;
      r_rd1          <= 32'd0;
      r_rd2          <= 32'd0;
      r_imm          <= 32'd0;
      r_alu_src      <= 1'b0;
      r_bubble_count <= 16'd0;
    end else begin
      r_valid     <= w_take;
      r_mem_read  <= w_take && bus.Mem_Read_ID;
      r_reg_write <= w_take && bus.Reg_Write_ID && !w_illegal;
      r_illegal   <= w_take && w_illegal;
      r_alu_ctrl  <= w_take ? w_alu_ctrl : ALU_ADD;
      r_write_reg <= !w_take ? 5'd0 : (bus.Reg_Dst_ID ? bus.Rd_ID : bus.Rt_ID);
      r_rd1       <= w_take ? bus.Read_Data_1_ID : 32'd0;
      r_rd2       <= w_take ? bus.Read_Data_2_ID : 32'd0;
      r_imm       <= w_take ? bus.Sign_Ext_Imm_ID : 32'd0;
      r_alu_src   <= w_take && bus.ALU_Src_ID;
      // Flush has priority, so a flushed hazard is not a counted stall.
      if (!bus.Flush_EX && w_hazard && (r_bubble_count != 16'hFFFF)) begin
        r_bubble_count <= r_bubble_count + 16'd1;
      end
    end
  end

`ifdef FORWARDING_EN
  // Source indices are only needed to match against the MEM/WB writers.
  logic [4:0] r_rs;
  logic [4:0] r_rt;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_rs <= 5'd0;
      r_rt <= 5'd0;
    end else begin
      r_rs <= w_take ? bus.Rs_ID : 5'd0;
      r_rt <= w_take ? bus.Rt_ID : 5'd0;
    end
  end

  assign w_rs_val = fwd_operand(r_rd1, r_rs,
                                bus.Reg_Write_MEM, bus.Write_Reg_MEM, bus.ALU_Result_MEM,
                                bus.Reg_Write_WB, bus.Write_Reg_WB, bus.Write_Data_WB);
  assign w_rt_val = fwd_operand(r_rd2, r_rt,
                                bus.Reg_Write_MEM, bus.Write_Reg_MEM, bus.ALU_Result_MEM,
                                bus.Reg_Write_WB, bus.Write_Reg_WB, bus.Write_Data_WB);
`else
  assign w_rs_val = r_rd1;
  assign w_rt_val = r_rd2;
`endif

  assign bus.Read_Data_1_EX = w_rs_val;
  assign bus.ALU_Data_2_EX  = r_alu_src ? r_imm : w_rt_val;
  assign bus.ALU_Control_EX = r_alu_ctrl;
  assign bus.Write_Reg_EX   = r_write_reg;
  assign bus.Mem_Read_EX    = r_mem_read;
  assign bus.Reg_Write_EX   = r_reg_write;
  assign bus.Valid_EX       = r_valid;
  assign bus.Illegal_EX     = r_illegal;
  assign bus.Bubble_Count   = r_bubble_count;

endmodule

// File: tb/tb_id_ex_issue.sv
// tb/tb_id_ex_issue.sv - self-checking bench for id_ex_issue (FORWARDING_EN optional)
module tb_id_ex_issue;
  import id_ex_issue_pkg::*;

  logic Clk;
  logic Reset_n;
  int   errors;
  int   checks;

  id_ex_issue_if bus ();

  id_ex_issue dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: EX-stage contents as plain variables
  bit        m_valid, m_mr, m_rw, m_ill;
  bit [3:0]  m_ctrl;
  bit [4:0]  m_wr;
  bit [31:0] m_rd1, m_d2;
  int        m_cnt;
  int        funct_map [bit [5:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] rd,
                       input bit [31:0] d1, input bit [31:0] d2, input bit [31:0] imm,
                       input bit [1:0] op, input bit [5:0] f,
                       input bit src, input bit dst, input bit mr, input bit rw);
    bus.Valid_ID = v;        bus.Rs_ID = rs;           bus.Rt_ID = rt;
    bus.Rd_ID = rd;          bus.Read_Data_1_ID = d1;  bus.Read_Data_2_ID = d2;
    bus.Sign_Ext_Imm_ID = imm; bus.ALU_Op_ID = op;     bus.Funct_ID = f;
    bus.ALU_Src_ID = src;    bus.Reg_Dst_ID = dst;     bus.Mem_Read_ID = mr;
    bus.Reg_Write_ID = rw;
  endtask

  task automatic load_r8();   // lw $8, 4($1)
    drive(1, 5'd1, 5'd8, 5'd0, 32'd100, 32'd200, 32'd4, 2'b00, 6'd0, 1, 0, 1, 1);
  endtask

  task automatic add_rs8();   // add $9, $8, $6
    drive(1, 5'd8, 5'd6, 5'd9, 32'd11, 32'd22, 32'd0, 2'b10, 6'b100000, 0, 1, 0, 1);
  endtask

  task automatic model_reset();
    m_valid = 0; m_mr = 0; m_rw = 0; m_ill = 0; m_ctrl = 4'b0010;
    m_wr = 0; m_rd1 = 0; m_d2 = 0; m_cnt = 0;
  endtask

  initial begin
    bit [4:0]  rs, rt, rd;
    bit [31:0] d1, d2, imm;
    bit [1:0]  op;
    bit [5:0]  f;
    bit        v, src, dst, mr, rw, fl, haz, ill;
    bit [3:0]  code;

    errors = 0;
    checks = 0;
    funct_map[6'b100000] = 2;  funct_map[6'b100010] = 6;
    funct_map[6'b100100] = 0;  funct_map[6'b100101] = 1;
    funct_map[6'b101010] = 7;

    Reset_n = 1'b0;
    bus.Flush_EX = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef FORWARDING_EN
    bus.ALU_Result_MEM = 0; bus.Write_Reg_MEM = 0; bus.Reg_Write_MEM = 0;
    bus.Write_Data_WB = 0;  bus.Write_Reg_WB = 0;  bus.Reg_Write_WB = 0;
`endif
    #12;
    chk("rst_valid", bus.Valid_EX, 0);
    chk("rst_ctrl", bus.ALU_Control_EX, 4'b0010);
    chk("rst_count", bus.Bubble_Count, 0);
    chk("rst_ready", bus.Ready_ID, 1);
    chk("rst_regwrite", bus.Reg_Write_EX, 0);
    chk("rst_rd1", bus.Read_Data_1_EX, 0);
    @(negedge Clk);
    Reset_n = 1'b1;

    // add $7, $5, $6 with operands 3 and 4
    drive(1, 5'd5, 5'd6, 5'd7, 32'd3, 32'd4, 32'd99, 2'b10, 6'b100000, 0, 1, 0, 1);
    #1 chk("add_ready", bus.Ready_ID, 1);
    tick();
    chk("add_ctrl", bus.ALU_Control_EX, 4'b0010);
    chk("add_rd1", bus.Read_Data_1_EX, 3);
    chk("add_d2", bus.ALU_Data_2_EX, 4);
    chk("add_wr", bus.Write_Reg_EX, 7);
    chk("add_valid", bus.Valid_EX, 1);
    chk("add_rw", bus.Reg_Write_EX, 1);

    // load-use: one-cycle stall then issue
    load_r8();
    tick();
    chk("lw_mr", bus.Mem_Read_EX, 1);
    chk("lw_wr", bus.Write_Reg_EX, 8);
    chk("lw_d2_imm", bus.ALU_Data_2_EX, 4);
    add_rs8();
    #1 chk("lu_ready", bus.Ready_ID, 0);
    tick();
    chk("lu_bubble_valid", bus.Valid_EX, 0);
    chk("lu_bubble_wr", bus.Write_Reg_EX, 0);
    chk("lu_count", bus.Bubble_Count, 1);
    chk("lu_ready_after", bus.Ready_ID, 1);
    tick();
    chk("lu_issue_valid", bus.Valid_EX, 1);
    chk("lu_issue_rd1", bus.Read_Data_1_EX, 11);
    chk("lu_issue_wr", bus.Write_Reg_EX, 9);

    // flush together with a hazard
    load_r8();
    tick();
    add_rs8();
    bus.Flush_EX = 1'b1;
    #1 chk("fl_ready", bus.Ready_ID, 1);
    tick();
    bus.Flush_EX = 1'b0;
    chk("fl_valid", bus.Valid_EX, 0);
    chk("fl_count", bus.Bubble_Count, 1);

    // rt matches the load but the immediate replaces it: no hazard
    load_r8();
    tick();
    drive(1, 5'd2, 5'd8, 5'd0, 32'd1, 32'd2, 32'd3, 2'b00, 6'd0, 1, 0, 0, 1);
    #1 chk("imm_rt_ready", bus.Ready_ID, 1);
    // load to $0 never stalls
    tick();
    drive(1, 5'd1, 5'd0, 5'd0, 32'd0, 32'd0, 32'd4, 2'b00, 6'd0, 1, 0, 1, 1);
    tick();
    drive(1, 5'd0, 5'd0, 5'd3, 32'd0, 32'd0, 32'd0, 2'b10, 6'b100000, 0, 1, 0, 1);
    #1 chk("r0_ready", bus.Ready_ID, 1);
    tick();

    // illegal funct
    drive(1, 5'd2, 5'd3, 5'd4, 32'd5, 32'd6, 32'd0, 2'b10, 6'b000111, 0, 1, 0, 1);
    tick();
    chk("ill_flag", bus.Illegal_EX, 1);
    chk("ill_rw", bus.Reg_Write_EX, 0);
    chk("ill_ctrl", bus.ALU_Control_EX, 4'b0010);
    chk("ill_valid", bus.Valid_EX, 1);

    // reset in the middle of a stall
    load_r8();
    tick();
    add_rs8();
    #1 chk("mid_ready0", bus.Ready_ID, 0);
    Reset_n = 1'b0;
    #1;
    chk("mid_valid", bus.Valid_EX, 0);
    chk("mid_count", bus.Bubble_Count, 0);
    chk("mid_ready1", bus.Ready_ID, 1);
    @(negedge Clk);
    Reset_n = 1'b1;
    tick();
    chk("mid_issue_valid", bus.Valid_EX, 1);
    chk("mid_issue_rd1", bus.Read_Data_1_EX, 11);

`ifdef FORWARDING_EN
    drive(1, 5'd9, 5'd10, 5'd11, 32'h11, 32'h22, 32'd0, 2'b10, 6'b100000, 0, 1, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.Reg_Write_MEM = 1; bus.Write_Reg_MEM = 9; bus.ALU_Result_MEM = 32'h55;
    bus.Reg_Write_WB = 1;  bus.Write_Reg_WB = 9;  bus.Write_Data_WB = 32'hAA;
    #1 chk("fwd_mem", bus.Read_Data_1_EX, 32'h55);
    bus.Write_Reg_MEM = 0;
    #1 chk("fwd_wb", bus.Read_Data_1_EX, 32'hAA);
    bus.Reg_Write_MEM = 0; bus.Reg_Write_WB = 0;
    #1 chk("fwd_none", bus.Read_Data_1_EX, 32'h11);
    @(negedge Clk);
`endif

    // saturation: preload near the top, then two more load-use stalls
    @(negedge Clk);
    force dut.r_bubble_count = 16'hFFFE;
    #1 release dut.r_bubble_count;
    for (int k = 0; k < 2; k++) begin
      load_r8();
      tick();
      add_rs8();
      tick();
      chk("sat_count", bus.Bubble_Count, 16'hFFFF);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end

    // randomized run against the reference model
    @(negedge Clk);
    Reset_n = 1'b0;
    model_reset();
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int n = 0; n < 400; n++) begin
      v   = ($urandom_range(7) != 0);
      rs  = 5'($urandom_range(3));
      rt  = 5'($urandom_range(3));
      rd  = 5'($urandom_range(31));
      d1  = $urandom;
      d2  = $urandom;
      imm = $urandom;
      op  = 2'($urandom_range(3));
      case ($urandom_range(5))
        0: f = 6'b100000;  1: f = 6'b100010;  2: f = 6'b100100;
        3: f = 6'b100101;  4: f = 6'b101010;  default: f = 6'($urandom_range(63));
      endcase
      src = $urandom_range(1);
      dst = $urandom_range(1);
      mr  = ($urandom_range(2) == 0);
      rw  = $urandom_range(1);
      fl  = ($urandom_range(7) == 0);
      drive(v, rs, rt, rd, d1, d2, imm, op, f, src, dst, mr, rw);
      bus.Flush_EX = fl;
      haz = m_valid && m_mr && (m_wr != 0) && ((m_wr == rs) || ((m_wr == rt) && !src));
      #1 chk("rnd_ready", bus.Ready_ID, !haz || fl);

      ill = 0;
      case (op)
        2'b00: code = 4'd2;
        2'b01: code = 4'd6;
        2'b11: code = 4'd1;
        default: if (funct_map.exists(f)) code = 4'(funct_map[f]);
                 else begin code = 4'd2; ill = 1; end
      endcase
      if (fl || haz || !v) begin
        if (!fl && haz && m_cnt < 65535) m_cnt++;
        m_valid = 0; m_mr = 0; m_rw = 0; m_ill = 0; m_ctrl = 4'd2;
        m_wr = 0; m_rd1 = 0; m_d2 = 0;
      end else begin
        m_valid = 1; m_mr = mr; m_rw = rw && !ill; m_ill = ill; m_ctrl = code;
        m_wr = dst ? rd : rt; m_rd1 = d1; m_d2 = src ? imm : d2;
      end
      tick();
      chk("rnd_valid", bus.Valid_EX, m_valid);
      chk("rnd_mr", bus.Mem_Read_EX, m_mr);
      chk("rnd_rw", bus.Reg_Write_EX, m_rw);
      chk("rnd_ill", bus.Illegal_EX, m_ill);
      chk("rnd_ctrl", bus.ALU_Control_EX, m_ctrl);
      chk("rnd_wr", bus.Write_Reg_EX, m_wr);
      chk("rnd_rd1", bus.Read_Data_1_EX, m_rd1);
      chk("rnd_d2", bus.ALU_Data_2_EX, m_d2);
      chk("rnd_count", bus.Bubble_Count, m_cnt[15:0]);
    end
    bus.Flush_EX = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
